// File: rtl/end_screen_sequencer.sv
// End-of-game screen engine: row-by-row map reveal, highlight blink, restart handshake.
// Optional feature macro: BOUNCE_ANIM_EN (triangle-wave bounce of the character).

module end_screen_sequencer #(
    parameter int NUM_SCREENS   = 2,
    parameter int MAP_ROWS      = 12,
    parameter int MAP_COLS      = 17,
    parameter int REVEAL_FRAMES = 4,
    parameter int HOLD_FRAMES   = 60,
    parameter int BLINK_FRAMES  = 30,
    parameter int BDR           = 0,
    parameter int SKY           = 1,
    parameter int TKN           = 4,
    parameter int MARIO_X       = 200,
    parameter int MARIO_Y_BASE  = 200,
    parameter int BOUNCE_AMP    = 16,
    parameter int HIDE_POS      = 1000,
    // one spare bit so an out-of-range selector from the controller is visible and clamps to map 0
    localparam int SEL_W        = $clog2(NUM_SCREENS) + 1
) (
    input  logic             vga_clock,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             show,
    input  logic [SEL_W-1:0] screen_sel,
    input  logic             jump_button,
    input  logic             restart_ack,
    input  logic [3:0]       tile_row,
    input  logic [4:0]       tile_col,
    output logic [7:0]       tile_code,
    output logic [15:0]      mario_x,
    output logic [15:0]      mario_y,
    output logic             restart_req,
    output logic [2:0]       state_dbg
);

    // state   | meaning
    // IDLE    | nothing shown, character hidden
    // REVEAL  | map rows appear one every REVEAL_FRAMES frames
    // HOLD    | full map, button ignored for HOLD_FRAMES frames
    // ARMED   | highlight blinking, waiting for a jump press
    // REQUEST | restart_req high until restart_ack
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REVEAL  = 3'd1,
        S_HOLD    = 3'd2,
        S_ARMED   = 3'd3,
        S_REQUEST = 3'd4
    } state_t;

    localparam int SCR_W     = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;
    localparam int RW        = $clog2(MAP_ROWS + 1);
    localparam int FRAME_MAX = ((REVEAL_FRAMES > HOLD_FRAMES) ? REVEAL_FRAMES : HOLD_FRAMES) - 1;
    localparam int FW        = (FRAME_MAX > 0) ? $clog2(FRAME_MAX + 1) : 1;
    localparam int BLW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int BW        = $clog2(BOUNCE_AMP + 1);

    localparam logic [7:0]  T_BDR  = 8'(BDR);
    localparam logic [7:0]  T_SKY  = 8'(SKY);
    localparam logic [7:0]  T_TKN  = 8'(TKN);
    localparam logic [15:0] X_SHOW = 16'(MARIO_X);
    localparam logic [15:0] Y_BASE = 16'(MARIO_Y_BASE);
    localparam logic [15:0] P_HIDE = 16'(HIDE_POS);

    state_t           state;
    logic [SCR_W-1:0] scr_q;
    logic [RW-1:0]    rows_shown;
    logic [FW-1:0]    frame_tmr;
    logic [BLW-1:0]   blink_tmr;
    logic             blink_phase;
    logic             jump_prev;
    logic             drop;
    logic [7:0]       map_code;
    logic [7:0]       lookup_code;
    logic [BW-1:0]    bounce_step;

    // Map 0: game over (sky interior, text on row 6); other maps: win (sky top, ground below).
    function automatic logic [7:0] map_tile(input logic [SCR_W-1:0] s,
                                            input logic [3:0] r,
                                            input logic [4:0] c);
        logic [7:0] t;
        if (r == 4'd0 || int'(r) == MAP_ROWS - 1 || c == 5'd0 || int'(c) == MAP_COLS - 1)
            t = T_BDR;
        else if (r == 4'd6 && c >= 5'd4 && c <= 5'd12)
            t = ((s == '0) ? 8'h10 : 8'h30) + {3'b000, c};
        else if (s == '0 || r <= 4'd3)
            t = T_SKY;
        else
            t = 8'h02;
        return t;
    endfunction

    always_comb begin
        drop = ((state == S_REVEAL || state == S_HOLD || state == S_ARMED) && !show)
             || (state == S_REQUEST && restart_ack);
    end

    always_comb begin
        map_code    = T_BDR;
        lookup_code = T_BDR;
        if (int'(tile_row) < MAP_ROWS && int'(tile_col) < MAP_COLS) begin
            map_code = map_tile(scr_q, tile_row, tile_col);
            case (state)
                S_REVEAL:          if (int'(tile_row) < int'(rows_shown)) lookup_code = map_code;
                S_HOLD, S_REQUEST: lookup_code = map_code;
                S_ARMED:           lookup_code = (blink_phase && map_code == T_SKY) ? T_TKN : map_code;
                default:           lookup_code = T_BDR;
            endcase
        end
    end

`ifdef BOUNCE_ANIM_EN
    logic [BW-1:0] bounce;
    logic          bounce_up;

    always_comb begin
        bounce_step = bounce_up ? bounce + 1'b1 : bounce - 1'b1;
    end
`else
    assign bounce_step = '0;
`endif

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state       <= S_IDLE;
            scr_q       <= '0;
            rows_shown  <= '0;
            frame_tmr   <= '0;
            blink_tmr   <= '0;
            blink_phase <= 1'b0;
            jump_prev   <= 1'b0;
            restart_req <= 1'b0;
            tile_code   <= T_BDR;
            mario_x     <= P_HIDE;
            mario_y     <= P_HIDE;
`ifdef BOUNCE_ANIM_EN
            bounce      <= '0;
            bounce_up   <= 1'b1;
`endif
        end else begin
            jump_prev <= jump_button;
            tile_code <= lookup_code;

            if ((state == S_HOLD || state == S_ARMED) && frame_start) begin
                if (blink_tmr == '0) begin
                    blink_tmr   <= BLW'(BLINK_FRAMES - 1);
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_tmr <= blink_tmr - 1'b1;
                end
            end

            if (state != S_IDLE && frame_start) begin
                mario_y <= Y_BASE - 16'(bounce_step);
`ifdef BOUNCE_ANIM_EN
                bounce <= bounce_step;
                if (bounce_up && bounce_step == BW'(BOUNCE_AMP))
                    bounce_up <= 1'b0;
                else if (!bounce_up && bounce_step == '0)
                    bounce_up <= 1'b1;
`endif
            end

            // leaving for IDLE overrides any frame or button activity in the same cycle
            if (drop) begin
                state       <= S_IDLE;
                restart_req <= 1'b0;
                rows_shown  <= '0;
                frame_tmr   <= '0;
                blink_tmr   <= '0;
                blink_phase <= 1'b0;
                mario_x     <= P_HIDE;
                mario_y     <= P_HIDE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (show) begin
                            scr_q      <= (screen_sel >= SEL_W'(NUM_SCREENS)) ? '0 : SCR_W'(screen_sel);
                            rows_shown <= '0;
                            frame_tmr  <= FW'(REVEAL_FRAMES - 1);
                            mario_x    <= X_SHOW;
                            mario_y    <= Y_BASE;
                            state      <= S_REVEAL;
`ifdef BOUNCE_ANIM_EN
                            bounce     <= '0;
                            bounce_up  <= 1'b1;
`endif
                        end
                    end
                    S_REVEAL: begin
                        if (frame_start) begin
                            if (frame_tmr != '0) begin
                                frame_tmr <= frame_tmr - 1'b1;
                            end else if (int'(rows_shown) == MAP_ROWS - 1) begin
                                rows_shown  <= RW'(MAP_ROWS);
                                frame_tmr   <= FW'(HOLD_FRAMES - 1);
                                blink_tmr   <= BLW'(BLINK_FRAMES - 1);
                                blink_phase <= 1'b0;
                                state       <= S_HOLD;
                            end else begin
                                rows_shown <= rows_shown + 1'b1;
                                frame_tmr  <= FW'(REVEAL_FRAMES - 1);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (frame_start) begin
                            if (frame_tmr != '0)
                                frame_tmr <= frame_tmr - 1'b1;
                            else
                                state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (jump_button && !jump_prev) begin
                            state       <= S_REQUEST;
                            restart_req <= 1'b1;
                            blink_phase <= 1'b0;
                            blink_tmr   <= '0;
                        end
                    end
                    S_REQUEST: restart_req <= 1'b1;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_end_screen_sequencer.sv
// Directed bench for end_screen_sequencer; expected values are hand-derived constants.

module tb_end_screen_sequencer;

    logic        vga_clock   = 1'b0;
    logic        reset       = 1'b1;
    logic        frame_start = 1'b0;
    logic        show        = 1'b0;
    logic [1:0]  screen_sel  = 2'd0;
    logic        jump_button = 1'b0;
    logic        restart_ack = 1'b0;
    logic [3:0]  tile_row    = 4'd0;
    logic [4:0]  tile_col    = 5'd0;
    logic [7:0]  tile_code;
    logic [15:0] mario_x;
    logic [15:0] mario_y;
    logic        restart_req;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    end_screen_sequencer dut (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .frame_start (frame_start),
        .show        (show),
        .screen_sel  (screen_sel),
        .jump_button (jump_button),
        .restart_ack (restart_ack),
        .tile_row    (tile_row),
        .tile_col    (tile_col),
        .tile_code   (tile_code),
        .mario_x     (mario_x),
        .mario_y     (mario_y),
        .restart_req (restart_req),
        .state_dbg   (state_dbg)
    );

    always #5 vga_clock = ~vga_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
    endtask

    task automatic look(input string tag, input int r, input int c, input logic [31:0] exp);
        tile_row = 4'(r);
        tile_col = 5'(c);
        tick();
        check(tag, tile_code, exp);
    endtask

    function automatic int exp_y(input int i);
`ifdef BOUNCE_ANIM_EN
        if (i <= 16)      return 200 - i;
        else if (i <= 32) return 200 - (32 - i);
        else              return 200 - (i - 32);
`else
        return 200 + 0 * i;
`endif
    endfunction

    initial begin
        // reset values
        tick();
        tick();
        check("rst_state", state_dbg, 0);
        check("rst_req", restart_req, 0);
        check("rst_tile", tile_code, 0);
        check("rst_mario_x", mario_x, 1000);
        check("rst_mario_y", mario_y, 1000);
        reset = 1'b0;
        tick();
        check("idle_state", state_dbg, 0);
        look("idle_lookup", 1, 3, 0);

        // reveal of map 0, bounce profile over the first 33 frames
        screen_sel = 2'd0;
        show = 1'b1;
        tick();
        check("reveal_entry", state_dbg, 1);
        check("reveal_mario_x", mario_x, 200);
        check("bounce_y0", mario_y, 32'(exp_y(0)));
        for (int i = 1; i <= 48; i++) begin
            frames(1);
            if (i <= 33) check("bounce_y", mario_y, 32'(exp_y(i)));
            if (i == 8) begin
                look("row1_visible", 1, 3, 1);
                look("row2_hidden", 2, 3, 0);
            end
            if (i == 47) check("still_reveal", state_dbg, 1);
        end
        check("hold_entry", state_dbg, 2);

        // HOLD: press at frame 30 discarded; button held over the ARMED entry
        for (int i = 1; i <= 60; i++) begin
            frames(1);
            if (i == 30) begin
                jump_button = 1'b1;
                tick();
                jump_button = 1'b0;
                tick();
                check("hold_press_state", state_dbg, 2);
                check("hold_press_req", restart_req, 0);
            end
            if (i == 58) jump_button = 1'b1;
        end
        check("armed_entry", state_dbg, 3);
        tick();
        tick();
        check("held_no_trigger", state_dbg, 3);
        check("held_no_req", restart_req, 0);
        jump_button = 1'b0;
        tick();

        // ARMED blink and lookup latency
        look("armed_sky", 1, 3, 1);
        look("armed_bdr", 0, 0, 0);
        frames(30);
        look("blink_bdr", 0, 0, 0);
        tile_row = 4'd1;
        tile_col = 5'd3;
        #1;
        check("latency_0", tile_code, 0);
        tick();
        check("latency_1_tkn", tile_code, 4);
        look("blink_text", 6, 4, 8'h14);
        frames(30);
        look("blink_off", 1, 3, 1);
        look("bdr_again", 0, 0, 0);

        // restart handshake, show ignored while requesting
        jump_button = 1'b1;
        tick();
        check("req_rise", restart_req, 1);
        check("req_state", state_dbg, 4);
        jump_button = 1'b0;
        show = 1'b0;
        tick();
        check("req_show_ignored", state_dbg, 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("req_hold", restart_req, 1);
        end
        restart_ack = 1'b1;
        tick();
        restart_ack = 1'b0;
        check("ack_req", restart_req, 0);
        check("ack_state", state_dbg, 0);
        check("ack_mario_x", mario_x, 1000);

        // show dropped together with a frame_start
        show = 1'b1;
        tick();
        frames(5);
        show = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("drop_state", state_dbg, 0);
        check("drop_mario_x", mario_x, 1000);
        check("drop_mario_y", mario_y, 1000);
        look("drop_lookup", 1, 3, 0);
        look("drop_text", 6, 4, 0);

        // out-of-range selector clamps to map 0; out-of-range lookups
        screen_sel = 2'd3;
        show = 1'b1;
        tick();
        check("clamp_reveal", state_dbg, 1);
        frames(48);
        check("clamp_hold", state_dbg, 2);
        look("clamp_8_2", 8, 2, 1);
        look("clamp_6_4", 6, 4, 8'h14);
        look("row_oob", 12, 0, 0);
        look("col_oob", 0, 17, 0);
        look("both_oob", 15, 31, 0);

        // reset while requesting
        frames(60);
        check("t6_armed", state_dbg, 3);
        jump_button = 1'b1;
        tick();
        jump_button = 1'b0;
        check("t6_req", state_dbg, 4);
        reset = 1'b1;
        tick();
        check("rst_in_req", restart_req, 0);
        check("rst_in_req_state", state_dbg, 0);
        check("rst_in_req_mario", mario_y, 1000);
        check("rst_in_req_tile", tile_code, 0);
        show = 1'b0;
        reset = 1'b0;
        tick();

        // map 1 selection
        screen_sel = 2'd1;
        show = 1'b1;
        tick();
        frames(48);
        look("sel1_8_2", 8, 2, 2);
        look("sel1_1_3", 1, 3, 1);
        look("sel1_6_4", 6, 4, 8'h34);
        show = 1'b0;
        tick();
        check("final_idle", state_dbg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
